// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-access stage.
package mem_pkg;

  // RV32I load/store funct3 encodings
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  // Transaction sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } mem_state_t;

  // True when a load (is_load=1) or store (is_load=0) with this funct3 and
  // low address bits must be rejected: illegal size code or misaligned.
  function automatic logic f_access_fault(input logic       is_load,
                                          input logic [2:0] f3,
                                          input logic [1:0] lo);
    logic flt;
    flt = 1'b1;
    case (f3)
      F3_B:    flt = 1'b0;
      F3_H:    flt = lo[0];
      F3_W:    flt = (lo != 2'b00);
      F3_BU:   flt = ~is_load;
      F3_HU:   flt = ~is_load | lo[0];
      default: flt = 1'b1;
    endcase
    return flt;
  endfunction

endpackage

// File: rtl/load_align.sv
// Extracts and sign/zero-extends the addressed byte/halfword of a read word.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_lane,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Select the byte lane and the halfword lane from the read word
  always_comb begin
    w_byte = 8'd0;
    case (i_lane)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      2'd3:    w_byte = i_rdata[31:24];
      default: w_byte = 8'd0;
    endcase
    if (i_lane[1]) begin
      w_half = i_rdata[31:16];
    end else begin
      w_half = i_rdata[15:0];
    end
  end

  // Extend according to access size and signedness
  always_comb begin
    o_result = 32'd0;
    case (i_funct3)
      F3_B:    o_result = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_result = {24'd0, w_byte};
      F3_H:    o_result = {{16{w_half[15]}}, w_half};
      F3_HU:   o_result = {16'd0, w_half};
      F3_W:    o_result = i_rdata;
      default: o_result = 32'd0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RISC-V memory-access stage: one data-memory transaction per load/store,
// with byte-enable/lane encoding on stores and extraction on loads.
module mem_stage
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_m,
  input  logic        mem_read_m,
  input  logic        mem_write_m,
  input  logic [2:0]  funct3_m,
  input  logic [31:0] alu_result_m,
  input  logic [31:0] store_data_m,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] mem_data_m,
  output logic        stall_m,
  output logic        mem_done,
  output logic        misalign_m
);

  mem_state_t  r_state;
  mem_state_t  w_next_state;

  logic [31:0] r_addr;
  logic [2:0]  r_funct3;
  logic        r_we;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic [31:0] r_mem_data;
  logic        r_misalign;

  logic        w_access;
  logic        w_fault;
  logic        w_start;
  logic [31:0] w_wdata;
  logic [3:0]  w_be;
  logic [31:0] w_load;

  assign w_access = valid_m & (mem_read_m | mem_write_m);

  // Reject illegal or misaligned accesses before any request is issued
  always_comb begin
    w_fault = 1'b0;
    if (mem_read_m) begin
      w_fault = f_access_fault(1'b1, funct3_m, alu_result_m[1:0]);
    end else if (mem_write_m) begin
      w_fault = f_access_fault(1'b0, funct3_m, alu_result_m[1:0]);
    end else begin
      w_fault = 1'b0;
    end
  end

  assign w_start = (r_state == ST_IDLE) & w_access & ~w_fault;

  // Store lane replication and byte enables
  always_comb begin
    w_wdata = 32'd0;
    w_be    = 4'd0;
    case (funct3_m[1:0])
      2'b00: begin
        w_wdata = {4{store_data_m[7:0]}};
        w_be    = 4'b0001 << alu_result_m[1:0];
      end
      2'b01: begin
        w_wdata = {2{store_data_m[15:0]}};
        w_be    = 4'b0011 << {alu_result_m[1], 1'b0};
      end
      2'b10: begin
        w_wdata = store_data_m;
        w_be    = 4'b1111;
      end
      default: begin
        w_wdata = 32'd0;
        w_be    = 4'd0;
      end
    endcase
  end

  load_align u_load_align (
    .i_rdata  (dmem_rdata),
    .i_lane   (r_addr[1:0]),
    .i_funct3 (r_funct3),
    .o_result (w_load)
  );

  // Next-state sequencing for one request/response transaction
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_next_state = ST_REQ;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (dmem_ready) begin
          w_next_state = r_we ? ST_DONE : ST_WAIT;
        end else begin
          w_next_state = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (dmem_rvalid) begin
          w_next_state = ST_DONE;
        end else begin
          w_next_state = ST_WAIT;
        end
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State register; reset abandons any transaction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Latch request fields at start, capture load data, flag rejected accesses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= 32'd0;
      r_funct3   <= 3'd0;
      r_we       <= 1'b0;
      r_wdata    <= 32'd0;
      r_be       <= 4'd0;
      r_mem_data <= 32'd0;
      r_misalign <= 1'b0;
    end else begin
      if (w_start) begin
        r_addr   <= alu_result_m;
        r_funct3 <= funct3_m;
        r_we     <= mem_write_m;
        r_wdata  <= w_wdata;
        r_be     <= mem_write_m ? w_be : 4'd0;
      end
      if ((r_state == ST_WAIT) && dmem_rvalid) begin
        r_mem_data <= w_load;
      end
      r_misalign <= (r_state == ST_IDLE) & w_access & w_fault;
    end
  end

  assign dmem_req   = (r_state == ST_REQ);
  assign dmem_we    = r_we;
  assign dmem_addr  = {r_addr[31:2], 2'b00};
  assign dmem_wdata = r_wdata;
  assign dmem_be    = r_be;
  assign mem_data_m = r_mem_data;
  assign mem_done   = (r_state == ST_DONE);
  assign misalign_m = r_misalign;
  assign stall_m    = w_start | (r_state == ST_REQ) | (r_state == ST_WAIT);

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: transaction-level model plus
// directed load/store/fault/reset vectors.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_m, mem_read_m, mem_write_m;
  logic [2:0]  funct3_m;
  logic [31:0] alu_result_m, store_data_m;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic [31:0] mem_data_m;
  logic        stall_m, mem_done, misalign_m;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst_n(rst_n), .valid_m(valid_m), .mem_read_m(mem_read_m),
    .mem_write_m(mem_write_m), .funct3_m(funct3_m), .alu_result_m(alu_result_m),
    .store_data_m(store_data_m), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ready(dmem_ready), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .mem_data_m(mem_data_m), .stall_m(stall_m), .mem_done(mem_done),
    .misalign_m(misalign_m)
  );

  int checks = 0;
  int errors = 0;

  // model state
  logic        txn_live = 1'b0, txn_rd = 1'b0, start_pending = 1'b0;
  logic        in_req = 1'b0, in_wait = 1'b0;
  logic        exp_done = 1'b0, exp_mis = 1'b0, pend_mis = 1'b0;
  logic [31:0] exp_mem_data = 32'd0;
  logic [31:0] m_addr = 32'd0, m_wdata = 32'd0, m_result = 32'd0;
  logic [3:0]  m_be = 4'd0;
  logic        m_we = 1'b0;
  int          req_cnt = 0, wait_cnt = 0, rdy_delay = 0, rv_delay = 0;
  logic        rv_noise = 1'b0, force_rv = 1'b0;

  // observation statistics
  int stall_run = 0, last_stall_len = 0, req_run = 0, last_req_len = 0;
  int req_total = 0, mis_cnt = 0, done_cnt = 0;
  logic [31:0] last_req_wdata = 32'd0, last_req_addr = 32'd0;
  logic [3:0]  last_req_be = 4'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int f_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    else if (f3[1:0] == 2'b01) return 2;
    else return 4;
  endfunction

  function automatic logic f_fault(input logic rd, input logic [2:0] f3, input logic [31:0] a);
    logic ok;
    if (rd) ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    else    ok = (f3 <= 3'd2);
    return !ok || ((int'(a[1:0]) % f_size(f3)) != 0);
  endfunction

  function automatic logic [3:0] f_be(input logic [2:0] f3, input logic [31:0] a);
    logic [7:0] m;
    m = 8'((1 << f_size(f3)) - 1);
    m = m << a[1:0];
    return m[3:0];
  endfunction

  function automatic logic [31:0] f_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (f_size(f3) == 1) return (d & 32'h0000_00FF) * 32'h0101_0101;
    if (f_size(f3) == 2) return (d & 32'h0000_FFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] f_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] sh, v;
    sh = rd >> (8 * int'(a[1:0]));
    v  = rd;
    if (f_size(f3) == 1) begin
      v = sh & 32'h0000_00FF;
      if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
    end else if (f_size(f3) == 2) begin
      v = sh & 32'h0000_FFFF;
      if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
    end
    return v;
  endfunction

  // per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("stall_m", {31'd0, stall_m}, {31'd0, txn_live && !exp_done});
    chk("mem_done", {31'd0, mem_done}, {31'd0, exp_done});
    chk("misalign_m", {31'd0, misalign_m}, {31'd0, exp_mis});
    chk("mem_data_m", mem_data_m, exp_mem_data);
    chk("dmem_req", {31'd0, dmem_req}, {31'd0, in_req});
    if (in_req) begin
      chk("dmem_addr", dmem_addr, m_addr);
      chk("dmem_we", {31'd0, dmem_we}, {31'd0, m_we});
      chk("dmem_be", {28'd0, dmem_be}, {28'd0, m_be});
      if (m_we) chk("dmem_wdata", dmem_wdata, m_wdata);
    end
    if (stall_m) stall_run++;
    else begin
      if (stall_run != 0) last_stall_len = stall_run;
      stall_run = 0;
    end
    if (dmem_req) begin
      req_run++; req_total++;
      last_req_wdata = dmem_wdata; last_req_addr = dmem_addr; last_req_be = dmem_be;
    end else begin
      if (req_run != 0) last_req_len = req_run;
      req_run = 0;
    end
    if (misalign_m) mis_cnt++;
    if (mem_done) done_cnt++;
  end

  // advance one clock, apply the edge's handshake events, drive memory responses
  task automatic tick();
    logic done_prev;
    @(posedge clk); #1;
    done_prev = exp_done;
    exp_done = 1'b0;
    exp_mis = pend_mis;
    pend_mis = 1'b0;
    if (in_req && dmem_ready) begin
      in_req = 1'b0;
      if (txn_rd) begin in_wait = 1'b1; wait_cnt = 0; end
      else exp_done = 1'b1;
    end else if (in_wait && dmem_rvalid) begin
      in_wait = 1'b0;
      exp_mem_data = m_result;
      exp_done = 1'b1;
    end
    if (done_prev) txn_live = 1'b0;
    if (start_pending) begin start_pending = 1'b0; in_req = 1'b1; req_cnt = 0; end
    dmem_ready  = in_req && (req_cnt == rdy_delay);
    if (in_req) req_cnt++;
    dmem_rvalid = (in_wait && (wait_cnt == rv_delay)) || (rv_noise && in_req) || force_rv;
    if (in_wait) wait_cnt++;
  endtask

  task automatic clear_inputs();
    valid_m = 1'b0; mem_read_m = 1'b0; mem_write_m = 1'b0;
  endtask

  task automatic present(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d, input logic [31:0] rdat,
                         input int rdy_d, input int rv_d);
    valid_m = 1'b1; mem_read_m = rd; mem_write_m = wr; funct3_m = f3;
    alu_result_m = a; store_data_m = d; dmem_rdata = rdat;
    rdy_delay = rdy_d; rv_delay = rv_d; txn_rd = rd;
    m_addr = {a[31:2], 2'b00}; m_we = wr;
    m_be = wr ? f_be(f3, a) : 4'd0;
    m_wdata = f_wdata(f3, d);
    m_result = f_load(f3, a, rdat);
  endtask

  // run one access to completion; returns mem_data_m seen in the DONE cycle
  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d, input logic [31:0] rdat,
                       input int rdy_d, input int rv_d, output logic [31:0] done_data);
    int n;
    present(rd, wr, f3, a, d, rdat, rdy_d, rv_d);
    done_data = 32'd0;
    if (f_fault(rd, f3, a)) begin
      pend_mis = 1'b1;
      tick();
      clear_inputs();
      tick();
    end else begin
      txn_live = 1'b1;
      start_pending = 1'b1;
      for (n = 0; n < 200; n++) begin
        tick();
        if (exp_done) break;
      end
      if (n == 200) begin
        errors++;
        $display("FAIL timeout: access at 0x%08h never completed", a);
      end
      @(negedge clk);
      done_data = mem_data_m;
      tick();
      clear_inputs();
    end
  endtask

  logic [31:0] res;
  int          mis0, req0, done0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; clear_inputs(); funct3_m = 3'd0; alu_result_m = 32'd0;
    store_data_m = 32'd0; dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
    tick(); tick();
    @(negedge clk);
    chk("rst_dmem_addr", dmem_addr, 32'd0);
    chk("rst_dmem_wdata", dmem_wdata, 32'd0);
    chk("rst_dmem_be_we", {27'd0, dmem_be, dmem_we}, 32'd0);
    chk("rst_outs", {28'd0, dmem_req, stall_m, mem_done, misalign_m}, 32'd0);
    rst_n = 1'b1;
    tick();

    // SW, ready immediately
    issue(1'b0, 1'b1, 3'd2, 32'h0000_1000, 32'hDEAD_BEEF, 32'd0, 0, 0, res);
    chk("sw_be", {28'd0, last_req_be}, 32'h0000_000F);
    chk("sw_addr", last_req_addr, 32'h0000_1000);
    chk("sw_wdata", last_req_wdata, 32'hDEAD_BEEF);
    chk("sw_stall_len", last_stall_len, 32'd2);

    // SB, ready low two cycles, stray rvalid during REQ
    rv_noise = 1'b1;
    issue(1'b0, 1'b1, 3'd0, 32'h0000_1003, 32'h0000_00A5, 32'd0, 2, 0, res);
    rv_noise = 1'b0;
    chk("sb_req_len", last_req_len, 32'd3);
    chk("sb_wdata", last_req_wdata, 32'hA5A5_A5A5);
    chk("sb_be", {28'd0, last_req_be}, 32'h0000_0008);
    chk("sb_stall_len", last_stall_len, 32'd4);

    // byte loads
    issue(1'b1, 1'b0, 3'd0, 32'h0000_2002, 32'd0, 32'h12F4_5678, 0, 0, res);
    chk("lb_data", res, 32'hFFFF_FFF4);
    chk("lb_stall_len", last_stall_len, 32'd3);
    issue(1'b1, 1'b0, 3'd4, 32'h0000_2002, 32'd0, 32'h12F4_5678, 0, 0, res);
    chk("lbu_data", res, 32'h0000_00F4);

    // halfword loads; LH waits three cycles in WAIT
    issue(1'b1, 1'b0, 3'd1, 32'h0000_2002, 32'd0, 32'h8001_5678, 0, 2, res);
    chk("lh_data", res, 32'hFFFF_8001);
    chk("lh_stall_len", last_stall_len, 32'd5);
    issue(1'b1, 1'b0, 3'd2, 32'h0000_2004, 32'd0, 32'hCAFE_F00D, 1, 1, res);
    chk("lw_data", res, 32'hCAFE_F00D);
    issue(1'b1, 1'b0, 3'd5, 32'h0000_2000, 32'd0, 32'h8001_5678, 0, 0, res);
    chk("lhu_data", res, 32'h0000_5678);

    // rejected accesses
    mis0 = mis_cnt; req0 = req_total;
    issue(1'b1, 1'b0, 3'd2, 32'h0000_2001, 32'd0, 32'h1111_1111, 0, 0, res);
    chk("lw_mis_pulse", mis_cnt - mis0, 32'd1);
    chk("lw_mis_noreq", req_total - req0, 32'd0);
    chk("lw_mis_data", mem_data_m, 32'h0000_5678);
    issue(1'b0, 1'b1, 3'd1, 32'h0000_2003, 32'h1234_5678, 32'd0, 0, 0, res);
    chk("sh_mis_pulse", mis_cnt - mis0, 32'd2);
    chk("sh_mis_noreq", req_total - req0, 32'd0);
    issue(1'b1, 1'b0, 3'd3, 32'h0000_2000, 32'd0, 32'd0, 0, 0, res);
    issue(1'b0, 1'b1, 3'd4, 32'h0000_2000, 32'd0, 32'd0, 0, 0, res);
    chk("f3_mis_pulses", mis_cnt - mis0, 32'd4);
    chk("mis_data_kept", mem_data_m, 32'h0000_5678);

    // reset while waiting for read data
    done0 = done_cnt;
    present(1'b1, 1'b0, 3'd2, 32'h0000_2008, 32'd0, 32'h5555_AAAA, 0, 1000);
    txn_live = 1'b1; start_pending = 1'b1;
    tick(); tick(); tick(); tick();
    chk("rst_in_wait", {31'd0, stall_m}, 32'd1);
    rst_n = 1'b0; clear_inputs();
    txn_live = 1'b0; in_req = 1'b0; in_wait = 1'b0; start_pending = 1'b0;
    exp_done = 1'b0; exp_mem_data = 32'd0; dmem_rvalid = 1'b0; dmem_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    force_rv = 1'b1;
    tick();
    force_rv = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("rst_mid_data", mem_data_m, 32'd0);
    chk("rst_mid_nodone", done_cnt - done0, 32'd0);

    // sequencer back in IDLE: a fresh store completes with minimum latency
    issue(1'b0, 1'b1, 3'd1, 32'h0000_3002, 32'h0000_BEEF, 32'd0, 0, 0, res);
    chk("post_rst_stall", last_stall_len, 32'd2);
    chk("post_rst_wdata", last_req_wdata, 32'hBEEF_BEEF);
    chk("post_rst_be", {28'd0, last_req_be}, 32'h0000_000C);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
